// File: rtl/rhythm_pkg.sv
// rhythm_pkg: shared state encoding and step-length helper for the rhythm sequencer.
package rhythm_pkg;
    typedef enum logic [1:0] {EMPTY, ARMED, RUN} state_t;
    function automatic int len_eff(input int len, input int depth);
        return (len == 0 || len > depth) ? depth : len;
    endfunction
endpackage

// File: rtl/step_divider.sv
// step_divider: tempo counter producing one tick every div+1 enabled cycles.
module step_divider #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);
    logic [DIV_W-1:0] cnt_q, cnt_d;
    always_comb begin
        tick  = en && (cnt_q >= div);
        cnt_d = !en ? cnt_q : tick ? '0 : cnt_q + DIV_W'(1);
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
endmodule

// File: rtl/rhythm_step_ctrl.sv
// rhythm_step_ctrl: tempo-driven step sequencer; new patterns swap in only at bar boundaries.
module rhythm_step_ctrl
    import rhythm_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int DIV_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ena,
    input  logic [DIV_W-1:0]           div,
    input  logic [$clog2(DEPTH+1)-1:0] len,
    input  logic [DEPTH-1:0]           pat_data,
    input  logic                       pat_valid,
    output logic                       pat_ready,
    output logic                       step_tick,
    output logic [$clog2(DEPTH)-1:0]   step_idx,
    output logic                       gate,
    output logic                       bar_start,
    output logic                       pending
);
    localparam int IW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);
    state_t         state_q, state_d;
    logic [DEPTH-1:0] active_q, active_d, shadow_q, shadow_d;
    logic [IW-1:0]  idx_q, idx_d, step_idx_q, step_idx_d;
    logic [LW-1:0]  len_q, len_d, cur_len;
    logic           pending_q, pending_d, step_tick_q, step_tick_d;
    logic           gate_q, gate_d, bar_start_q, bar_start_d;
    logic           fire, accept, wrap, loaded;
    step_divider #(.DIV_W(DIV_W)) u_div (
        .clk(clk), .rst(rst), .en(state_q == RUN && ena), .div(div), .tick(fire)
    );
    always_comb begin
        accept      = pat_valid && !pending_q;
        loaded      = state_q != EMPTY;
        // Bar length is latched at step 0 so mid-bar edits never cut the running bar short.
        cur_len     = (idx_q == '0) ? LW'(len_eff(int'(len), DEPTH)) : len_q;
        wrap        = fire && (LW'(idx_q) == cur_len - LW'(1));
        state_d     = !loaded ? (accept ? (ena ? RUN : ARMED) : EMPTY) : (ena ? RUN : ARMED);
        active_d    = (!loaded && accept) ? pat_data : (wrap && pending_q) ? shadow_q : active_q;
        shadow_d    = (loaded && accept) ? pat_data : shadow_q;
        pending_d   = (loaded && accept) ? 1'b1 : wrap ? 1'b0 : pending_q;
        idx_d       = !fire ? idx_q : wrap ? '0 : idx_q + IW'(1);
        len_d       = (fire && idx_q == '0) ? cur_len : len_q;
        step_tick_d = fire;
        step_idx_d  = fire ? idx_q : step_idx_q;
        gate_d      = fire ? active_q[IW'(DEPTH-1) - idx_q] : gate_q;
        bar_start_d = fire && idx_q == '0;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q     <= EMPTY;
            active_q    <= '0;
            shadow_q    <= '0;
            pending_q   <= 1'b0;
            idx_q       <= '0;
            len_q       <= LW'(DEPTH);
            step_tick_q <= 1'b0;
            step_idx_q  <= '0;
            gate_q      <= 1'b0;
            bar_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            active_q    <= active_d;
            shadow_q    <= shadow_d;
            pending_q   <= pending_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            step_tick_q <= step_tick_d;
            step_idx_q  <= step_idx_d;
            gate_q      <= gate_d;
            bar_start_q <= bar_start_d;
        end
    assign pat_ready = !pending_q;
    assign pending   = pending_q;
    assign step_tick = step_tick_q;
    assign step_idx  = step_idx_q;
    assign gate      = gate_q;
    assign bar_start = bar_start_q;
endmodule
